// File: rtl/accum_cpu_pkg.sv
// accum_cpu_pkg: shared types and field-width helpers for the accumulator CPU.
//   opcode_t  - 4-bit instruction opcode
//   state_t   - fetch/decode/execute FSM states
//   OPC_W, instr_width() - instruction word layout {operand[AW-1:0], opcode[3:0]}
// Optional feature macro used by the design: ACCUM_CPU_CARRY_EN.
package accum_cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [3:0] {
    OP_HLT  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_STO  = 4'h3,
    OP_LD   = 4'h4,
    OP_B    = 4'h5,
    OP_BZ   = 4'h6,
    OP_LDV  = 4'h7,
    OP_INP  = 4'h8,
    OP_OUT  = 4'h9,
    OP_AND  = 4'hA,
    OP_OR   = 4'hB,
    OP_NOT  = 4'hC,
    OP_BC   = 4'hD,
    OP_NOP0 = 4'hE,
    OP_NOP1 = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WAIT_IN,
    ST_WAIT_OUT,
    ST_HALT
  } state_t;

  // Width of one program word for a given address width.
  function automatic int instr_width(input int aw);
    return OPC_W + aw;
  endfunction

endpackage

// File: rtl/accum_cpu_alu.sv
// accum_cpu_alu: combinational arithmetic/logic unit for the accumulator CPU.
// Ports:
//   opcode    in  - current instruction opcode
//   a         in  - accumulator value
//   b         in  - data RAM word read at the operand address
//   carry_in  in  - current carry flag (only with ACCUM_CPU_CARRY_EN)
//   result    out - new accumulator value (a when the opcode is not an ALU op)
//   carry_out out - next carry flag (only with ACCUM_CPU_CARRY_EN)
// Macro: ACCUM_CPU_CARRY_EN adds the carry ports.
module accum_cpu_alu
  import accum_cpu_pkg::*;
#(
  parameter int DW = 4
) (
  input  opcode_t         opcode,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
`ifdef ACCUM_CPU_CARRY_EN
  input  logic            carry_in,
  output logic            carry_out,
`endif
  output logic [DW-1:0]   result
);

  // One extra bit on each side catches the carry-out of ADD and the borrow of SUB.
  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = a;
    case (opcode)
      OP_ADD:  result = sum[DW-1:0];
      OP_SUB:  result = diff[DW-1:0];
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~a;
      OP_LD:   result = b;
      default: result = a;
    endcase
  end

`ifdef ACCUM_CPU_CARRY_EN
  // SUB reports NOT borrow, so carry=1 means a >= b.
  always_comb begin
    carry_out = carry_in;
    if (opcode == OP_ADD) begin
      carry_out = sum[DW];
    end else if (opcode == OP_SUB) begin
      carry_out = ~diff[DW];
    end
  end
`else
  logic unused_carry_bits;
  assign unused_carry_bits = sum[DW] ^ diff[DW];
`endif

endmodule

// File: rtl/accum_cpu.sv
// accum_cpu: parametrised accumulator processor with fetch/decode/execute FSM.
// Parameters: DW data/accumulator width (>= AW), AW program/data address width.
// Ports:
//   CLK, ResetN            - clock, synchronous active-low reset
//   Run                    - start pulse, honoured in IDLE or HALT (Pc cleared)
//   PramWe/PramAddr/PramData - host program RAM write, honoured in IDLE or HALT
//   InData/InValid/InReady - input handshake (InReady while waiting in WAIT_IN)
//   OutData/OutValid/OutReady - output handshake, OutValid registered
//   Busy, Halted           - status
//   Pc, Acc                - debug visibility
// Macro: ACCUM_CPU_CARRY_EN enables the carry flag and opcode D (BC);
//        without it opcode D executes as NOP.
module accum_cpu
  import accum_cpu_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic                 CLK,
  input  logic                 ResetN,
  input  logic                 Run,
  input  logic                 PramWe,
  input  logic [AW-1:0]        PramAddr,
  input  logic [OPC_W+AW-1:0]  PramData,
  input  logic [DW-1:0]        InData,
  input  logic                 InValid,
  output logic                 InReady,
  output logic [DW-1:0]        OutData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Busy,
  output logic                 Halted,
  output logic [AW-1:0]        Pc,
  output logic [DW-1:0]        Acc
);

  localparam int IW    = instr_width(AW);
  localparam int DEPTH = 1 << AW;

  state_t          state_reg, state_next;
  logic [IW-1:0]   pram [DEPTH];
  logic [DW-1:0]   dram [DEPTH];
  logic [IW-1:0]   ir_reg;
  logic [DW-1:0]   mem_reg;
  logic [AW-1:0]   pc_reg, pc_next;
  logic [DW-1:0]   acc_reg, acc_next;
  logic [DW-1:0]   out_data_reg;
  logic            out_valid_reg;
  logic [DW-1:0]   alu_result;
  opcode_t         opcode;
  logic [AW-1:0]   operand;

  assign opcode  = opcode_t'(ir_reg[OPC_W-1:0]);
  assign operand = ir_reg[IW-1:OPC_W];

`ifdef ACCUM_CPU_CARRY_EN
  logic carry_reg;
  logic alu_carry;
`endif

  accum_cpu_alu #(.DW(DW)) u_alu (
    .opcode    (opcode),
    .a         (acc_reg),
    .b         (mem_reg),
`ifdef ACCUM_CPU_CARRY_EN
    .carry_in  (carry_reg),
    .carry_out (alu_carry),
`endif
    .result    (alu_result)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    InReady    = 1'b0;
    Busy       = 1'b1;
    Halted     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        Busy = 1'b0;
        if (Run) state_next = ST_FETCH;
      end
      ST_HALT: begin
        Busy   = 1'b0;
        Halted = 1'b1;
        if (Run) state_next = ST_FETCH;
      end
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        case (opcode)
          OP_HLT:  state_next = ST_HALT;
          OP_INP:  state_next = ST_WAIT_IN;
          OP_OUT:  state_next = ST_WAIT_OUT;
          default: state_next = ST_FETCH;
        endcase
      end
      ST_WAIT_IN: begin
        // InReady depends on state only, never on InValid.
        InReady = 1'b1;
        if (InValid) state_next = ST_FETCH;
      end
      ST_WAIT_OUT: begin
        if (OutReady) state_next = ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    pc_next  = pc_reg;
    acc_next = acc_reg;
    case (state_reg)
      ST_IDLE, ST_HALT: begin
        if (Run) pc_next = '0;
      end
      ST_EXEC: begin
        pc_next = pc_reg + AW'(1);
        case (opcode)
          OP_HLT: pc_next = pc_reg;
          OP_B:   pc_next = operand;
          // BZ looks at the accumulator as it was before this instruction.
          OP_BZ:  if (acc_reg == '0) pc_next = operand;
`ifdef ACCUM_CPU_CARRY_EN
          OP_BC:  if (carry_reg) pc_next = operand;
`endif
          OP_LDV: acc_next = DW'(operand);
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_LD: acc_next = alu_result;
          default: ;
        endcase
      end
      ST_WAIT_IN: begin
        if (InValid) acc_next = InData;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      pc_reg        <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      acc_reg <= acc_next;
      if (state_reg == ST_EXEC && opcode == OP_OUT) begin
        out_data_reg  <= acc_reg;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && OutReady) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef ACCUM_CPU_CARRY_EN
  // The ALU passes carry through unchanged for opcodes other than ADD/SUB.
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      carry_reg <= 1'b0;
    end else if (state_reg == ST_EXEC) begin
      carry_reg <= alu_carry;
    end
  end
`endif

  // ---------------- memories (not reset) ----------------
  // Host writes only land while the core is idle or halted; a write in the
  // same cycle as Run is visible to the first FETCH.
  always_ff @(posedge CLK) begin
    if (ResetN && PramWe && !Busy) begin
      pram[PramAddr] <= PramData;
    end
    if (state_reg == ST_FETCH) begin
      ir_reg <= pram[pc_reg];
    end
  end

  // A reset asserted during EXEC must suppress the store.
  always_ff @(posedge CLK) begin
    if (ResetN && state_reg == ST_EXEC && opcode == OP_STO) begin
      dram[operand] <= acc_reg;
    end
    if (state_reg == ST_DECODE) begin
      mem_reg <= dram[operand];
    end
  end

  assign Pc       = pc_reg;
  assign Acc      = acc_reg;
  assign OutData  = out_data_reg;
  assign OutValid = out_valid_reg;

endmodule

// File: doc/accum_cpu.md
# accum_cpu

Parametrised accumulator processor, successor to the fixed 4-bit computer: same opcode set, generalised data width and address width, driven by an explicit fetch/decode/execute FSM. Input and output use ready/valid handshakes. Optional carry flag and branch-on-carry. Program RAM is loaded through a host port while the core is idle, then started with `Run`.

## Interface
- `DW`, 4: accumulator / data RAM word width; legal ≥ `AW`.
- `AW`, 4: program and data address width; both RAMs are 2^AW deep.
- `CLK` in 1: single clock, all logic on rising edge.
- `ResetN` in 1: reset is synchronous and active-low.
- `Run` in 1: start pulse; sampled in IDLE or HALT.
- `PramWe` in 1: program RAM write enable; honoured only in IDLE or HALT.
- `PramAddr` in AW: program RAM write address.
- `PramData` in 4+AW: {operand[AW-1:0], opcode[3:0]}.
- `InData` in DW: input port data.
- `InValid` in 1: input data valid.
- `InReady` out 1: core waiting in INP.
- `OutData` out DW: output register.
- `OutValid` out 1: OutData valid, held until accepted.
- `OutReady` in 1: consumer accepts OutData.
- `Busy` out 1: state not IDLE/HALT.
- `Halted` out 1: state is HALT.
- `Pc` out AW, `Acc` out DW: debug visibility.

## Operation
- Opcodes: 0 HLT, 1 ADD, 2 SUB, 3 STO, 4 LD, 5 B, 6 BZ, 7 LDV, 8 INP, 9 OUT, A AND, B OR, C NOT, D BC (carry build only), E/F NOP.
- ADD/SUB/AND/OR: Acc ← Acc op DRAM[operand]; SUB is Acc − mem; results mod 2^DW.
- LD: Acc ← DRAM[operand]. LDV: Acc ← zero-extended operand. NOT: Acc ← ~Acc. STO: DRAM[operand] ← Acc.
- B: Pc ← operand. BZ: Pc ← operand if Acc == 0, else Pc+1. BZ tests Acc before this instruction.
- INP: enter WAIT_IN with InReady=1; on InValid, Acc ← InData.
- OUT: OutData ← Acc, OutValid=1; enter WAIT_OUT; leave on OutReady.
- FSM states: IDLE, FETCH, DECODE, EXEC, WAIT_IN, WAIT_OUT, HALT.
- Transitions:
  - IDLE/HALT + Run → FETCH, with Pc←0.
  - FETCH → DECODE: synchronous PRAM read into IR.
  - DECODE → EXEC: synchronous DRAM read at operand.
  - EXEC → FETCH, or WAIT_IN / WAIT_OUT / HALT as the opcode requires.
  - WAIT_IN/WAIT_OUT → FETCH on handshake.
- Pc increments mod 2^AW; address 2^AW−1 wraps to 0.
- HLT: Pc is not advanced, Acc is retained.
- Restart from HALT keeps Acc and DRAM; only Pc is cleared.
- Run while Busy is ignored.
- PramWe while Busy is ignored. No write occurs.
- PramWe and Run together in IDLE: the write commits, and FETCH begins next cycle. The written word is visible if it is at address 0.

## Timing
- Reset values: state IDLE, Pc 0, Acc 0, OutData 0, OutValid 0, InReady 0, Busy 0, Halted 0, carry 0. RAM contents are not reset.
- ResetN low mid-instruction aborts it. Any pending STO in EXEC of that cycle is suppressed.
- Instruction latency is 3 cycles (FETCH, DECODE, EXEC). INP and OUT add one or more handshake cycles.
- Handshake timing:
  - InValid & InReady in cycle n: Acc is updated at the end of n, and FETCH occurs in n+1.
  - OutValid rises the cycle after EXEC.
  - OutValid drops the cycle after OutReady is seen high.
- InReady is combinational from state only, with no dependency on InValid. OutValid is registered.
- STO write and Acc update occur on the EXEC edge. STO followed by LD of the same address returns the new value.

## Configuration
- `ACCUM_CPU_CARRY_EN` defined:
  - 1-bit carry flag.
  - ADD sets carry to the carry-out.
  - SUB sets carry to NOT borrow.
  - Other opcodes hold carry.
  - Opcode D (BC): Pc ← operand if carry=1.
- `ACCUM_CPU_CARRY_EN` undefined: no carry register, and opcode D executes as NOP.

## Structure
- Package `accum_cpu_pkg` holds:
  - Opcode enum (4-bit).
  - FSM state enum.
  - Field-width helpers (opcode width 4).
- One combinational sub-module, `accum_cpu_alu`, with inputs opcode, a, b, and carry-in, and outputs result and carry-out. The carry port exists only under the macro.
- RAMs are inferred arrays inside `accum_cpu`.

## Test plan
- ResetN low 2 cycles -> all outputs at reset values; Pc=0, Acc=0, Busy=0.
- DW=4, program {LDV 5, ADD 0, STO 1, OUT, HLT} with DRAM[0]=3 -> OutData=8, Halted after 16 cycles with OutReady tied high.
- BZ loop: LDV 2, SUB 0 (DRAM[0]=1), BZ exit, B 1 -> loop taken once, exits with Acc=0.
- INP with InValid delayed 5 cycles -> InReady held 5 cycles, Acc=InData; OUT with OutReady low 4 cycles -> OutValid/OutData stable throughout.
- AW=4, program with no HLT -> Pc wraps 15→0; PramWe asserted while Busy -> PRAM unchanged.
- Carry build, DW=4: LDV 15, ADD (mem=1) -> Acc=0, carry=1, BC taken. Without the macro, the same program -> opcode D acts as NOP and Pc advances.
